load_align_unit: RTL and testbench

- Load-return path of the CPU memory stage; the read-side counterpart of the store mask/shift logic.
- Tracks each issued load through the data memory's fixed read latency, then extracts the addressed byte/halfword/word from the returned 32-bit word and sign- or zero-extends it.
- Buffers returns that arrive while the pipeline is stalled, so no load result is lost.
- Byte order is big-endian throughout: offset 0 = bits [31:24].

---
 rtl/load_align_unit.sv | 165 ++++++++++++++++
 tb/tb_load_align_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load-return path: tracks loads through memory latency, then aligns
// and extends the returned word; buffers returns that land during a stall.
module load_align_unit #(
  parameter int READ_LATENCY = 1,
  parameter int RD_WIDTH     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                LoadValid,
  input  logic [31:0]         Address,
  input  logic [1:0]          MemSize,
  input  logic                LoadUnsigned,
  input  logic [RD_WIDTH-1:0] LoadRd,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [31:0]         MemReadData,
  output logic                ResultValid,
  output logic [31:0]         ResultData,
  output logic [RD_WIDTH-1:0] ResultRd,
  output logic                Misaligned
);

  localparam int D  = READ_LATENCY;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic [1:0]          off;
    logic [1:0]          size;
    logic                uns;
    logic [RD_WIDTH-1:0] rd;
    logic                mis;
  } tag_t;

  typedef struct packed {
    logic [31:0]         data;
    logic [RD_WIDTH-1:0] rd;
    logic                mis;
  } res_t;

  logic          accept;
  tag_t          new_tag;
  logic [D-1:0]  tv_q;
  tag_t          tag_q [D];
  tag_t          xt;
  logic          arr_v;
  res_t          arr;
  logic [7:0]    b;
  logic [15:0]   h;
  logic          sel_b, sel_h, sel_w;
  res_t          pend_q [D];
  res_t          pend_d [D];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic          rv_q;
  res_t          out_q;
  logic          addr_unused;

  assign addr_unused = ^Address[31:2];
  assign accept = LoadValid & ~Stall & ~Flush;

  always_comb begin
    new_tag.off  = Address[1:0];
    new_tag.size = MemSize;
    new_tag.uns  = LoadUnsigned;
    new_tag.rd   = LoadRd;
    new_tag.mis  = ((MemSize == 2'b01) & Address[0])
                 | (MemSize[1] & (|Address[1:0]));
  end

  // Memory latency cannot be stalled, so the tag pipe always shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q <= '0;
      for (int i = 0; i < D; i++) tag_q[i] <= '0;
    end else begin
      tv_q[0]  <= accept;
      tag_q[0] <= new_tag;
      for (int i = 1; i < D; i++) begin
        tv_q[i]  <= tv_q[i-1] & ~Flush;
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign xt    = tag_q[D-1];
  assign arr_v = tv_q[D-1];
  assign sel_b = ~xt.mis & (xt.size == 2'b00);
  assign sel_h = ~xt.mis & (xt.size == 2'b01);
  assign sel_w = ~xt.mis & xt.size[1];

  always_comb begin
    b = MemReadData[31:24];
    unique case (xt.off)
      2'd0: b = MemReadData[31:24];
      2'd1: b = MemReadData[23:16];
      2'd2: b = MemReadData[15:8];
      2'd3: b = MemReadData[7:0];
    endcase
    h = xt.off[1] ? MemReadData[15:0]
                  : MemReadData[31:16];
    arr.rd   = xt.rd;
    arr.mis  = xt.mis;
    arr.data = '0;
    unique case (1'b1)
      sel_b:   arr.data = {{24{~xt.uns & b[7]}}, b};
      sel_h:   arr.data = {{16{~xt.uns & h[15]}}, h};
      sel_w:   arr.data = MemReadData;
      default: arr.data = '0;
    endcase
  end

  assign pop  = ~Stall & (cnt_q != '0);
  assign push = arr_v & (Stall | (cnt_q != '0));

  // Shift-register FIFO: head always at index 0.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (pop) begin
      for (int i = 0; i < D - 1; i++)
        pend_d[i] = pend_q[i+1];
      cnt_d = cnt_q - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < D; i++)
        if (CW'(i) == cnt_d) pend_d[i] = arr;
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < D; i++) pend_q[i] <= '0;
    end else begin
      cnt_q  <= Flush ? '0 : cnt_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q  <= 1'b0;
      out_q <= '0;
    end else if (Flush) begin
      rv_q <= 1'b0;
    end else if (!Stall) begin
      if (cnt_q != '0) begin
        rv_q  <= 1'b1;
        out_q <= pend_q[0];
      end else if (arr_v) begin
        rv_q  <= 1'b1;
        out_q <= arr;
      end else begin
        rv_q <= 1'b0;
      end
    end
  end

  assign ResultValid = rv_q;
  assign ResultData  = out_q.data;
  assign ResultRd    = out_q.rd;
  assign Misaligned  = out_q.mis;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: latency-1 and latency-2 instances share
// stimulus; a scoreboard per instance checks every delivered result.
module tb_load_align_unit;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LoadValid, LoadUnsigned, Stall, Flush;
  logic [31:0] Address;
  logic [1:0]  MemSize;
  logic [4:0]  LoadRd;
  logic [31:0] md [2];
  logic [1:0]  rv, mis;
  logic [31:0] rdat [2];
  logic [4:0]  rrd [2];
  logic [31:0] mem [2][8192];
  int          cyc;
  int          checks;
  int          failures;
  exp_t        q [2][$];
  exp_t        me;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign md[0] = mem[0][cyc[12:0]];
  assign md[1] = mem[1][cyc[12:0]];

  load_align_unit #(.READ_LATENCY(1), .RD_WIDTH(5)) u1 (
    .clk(clk), .rst_n(rst_n), .LoadValid(LoadValid),
    .Address(Address), .MemSize(MemSize),
    .LoadUnsigned(LoadUnsigned), .LoadRd(LoadRd),
    .Stall(Stall), .Flush(Flush), .MemReadData(md[0]),
    .ResultValid(rv[0]), .ResultData(rdat[0]),
    .ResultRd(rrd[0]), .Misaligned(mis[0])
  );

  load_align_unit #(.READ_LATENCY(2), .RD_WIDTH(5)) u2 (
    .clk(clk), .rst_n(rst_n), .LoadValid(LoadValid),
    .Address(Address), .MemSize(MemSize),
    .LoadUnsigned(LoadUnsigned), .LoadRd(LoadRd),
    .Stall(Stall), .Flush(Flush), .MemReadData(md[1]),
    .ResultValid(rv[1]), .ResultData(rdat[1]),
    .ResultRd(rrd[1]), .Misaligned(mis[1])
  );

  // Reference: pick the addressed lane arithmetically, then extend.
  function automatic logic [32:0] ref_load(
    input logic [31:0] w, input logic [1:0] off,
    input logic [1:0] sz, input logic uns);
    longint v;
    bit     m;
    m = 0;
    if (sz == 2'd0) begin
      v = longint'((w >> (8 * (3 - int'(off)))) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      m = off[0];
      v = longint'((w >> (16 * (1 - int'(off[1])))) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      m = (off != 2'd0);
      v = longint'(w);
    end
    if (m) v = 0;
    return {m, v[31:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // One clock cycle of stimulus; lx<0 disables the latency check.
  task automatic cycle(input bit lv, input logic [31:0] a,
                       input logic [1:0] sz, input bit u,
                       input logic [4:0] rd, input bit st,
                       input bit fl, input bit setw,
                       input logic [31:0] w, input int lx);
    exp_t        e;
    logic [32:0] r;
    @(posedge clk);
    #1;
    if (Flush) begin
      q[0].delete();
      q[1].delete();
    end
    LoadValid = lv; Address = a; MemSize = sz;
    LoadUnsigned = u; LoadRd = rd; Stall = st; Flush = fl;
    if (lv && !st && !fl) begin
      for (int k = 0; k < 2; k++) begin
        int t;
        t = cyc + k + 1;
        if (setw) mem[k][t[12:0]] = w;
        r = ref_load(mem[k][t[12:0]], a[1:0], sz, u);
        e.data = r[31:0];
        e.mis  = r[32];
        e.rd   = rd;
        e.due  = (lx < 0) ? -1 : t + 1 + lx;
        q[k].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic chk_zero_outs(input string n);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid%0d", n, k), 32'(rv[k]), 0);
      chk($sformatf("%s_data%0d", n, k), rdat[k], 0);
      chk($sformatf("%s_rd%0d", n, k), 32'(rrd[k]), 0);
      chk($sformatf("%s_mis%0d", n, k), 32'(mis[k]), 0);
    end
  endtask

  // Monitor: a result is consumed on any unstalled cycle it is valid.
  always @(negedge clk) begin
    if (rst_n && !Stall) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_result dut%0d actual=%h required=none",
                     k, rdat[k]);
          end else begin
            me = q[k].pop_front();
            chk($sformatf("mis%0d", k), 32'(mis[k]), 32'(me.mis));
            if (!me.mis)
              chk($sformatf("data%0d", k), rdat[k], me.data);
            chk($sformatf("rd%0d", k), 32'(rrd[k]), 32'(me.rd));
            if (me.due >= 0)
              chk($sformatf("latency%0d", k), cyc, me.due);
          end
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    LoadValid = 0; Address = 0; MemSize = 0; LoadUnsigned = 0;
    LoadRd = 0; Stall = 0; Flush = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8192; i++) mem[k][i] = $urandom;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Aligned and misaligned extraction, back to back, exact latency.
    cycle(1, 32'h1, 2'd0, 0, 5'd1, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h1, 2'd0, 1, 5'd2, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h2, 2'd1, 0, 5'd3, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h0, 2'd2, 0, 5'd4, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h1, 2'd1, 0, 5'd5, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h2, 2'd2, 0, 5'd6, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h3, 2'd0, 0, 5'd7, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h0, 2'd1, 1, 5'd8, 0, 0, 1, 32'h8899AABB, 0);
    cycle(1, 32'h1, 2'd3, 0, 5'd9, 0, 0, 1, 32'h8899AABB, 0);
    idle(6);

    // Two loads, then a 4-cycle stall while returns land.
    cycle(1, 32'h0, 2'd0, 0, 5'd10, 0, 0, 1, 32'hF0123456, 4);
    cycle(1, 32'h2, 2'd1, 1, 5'd11, 0, 0, 1, 32'h1234CDEF, 4);
    repeat (4) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    idle(6);

    // Stall release coinciding with a new return.
    cycle(1, 32'h3, 2'd0, 0, 5'd12, 0, 0, 0, 0, 1);
    cycle(1, 32'h0, 2'd1, 0, 5'd13, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    cycle(1, 32'h0, 2'd2, 0, 5'd14, 0, 0, 0, 0, 0);
    idle(6);

    // Flush with loads in flight and pending.
    cycle(1, 32'h0, 2'd2, 0, 5'd15, 0, 0, 0, 0, -1);
    cycle(1, 32'h0, 2'd2, 0, 5'd16, 0, 0, 0, 0, -1);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, -1);
    cycle(1, 32'h0, 2'd2, 0, 5'd17, 0, 0, 0, 0, -1);
    cycle(1, 32'h0, 2'd2, 0, 5'd18, 0, 1, 0, 0, -1);
    cycle(1, 32'h1, 2'd0, 0, 5'd19, 0, 0, 0, 0, 0);
    chk("flush_valid0", 32'(rv[0]), 0);
    chk("flush_valid1", 32'(rv[1]), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("flush_valid1b", 32'(rv[1]), 0);
    idle(6);

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      bit st, fl, lv;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 79) == 0);
      lv = ($urandom_range(0, 3) != 0) &&
           (st || fl || (q[0].size() < 2 && q[1].size() < 3));
      cycle(lv, $urandom, 2'($urandom), 1'($urandom),
            5'($urandom), st, fl, 0, 0, -1);
    end
    idle(1);
    for (int i = 0; i < 100; i++)
      if (q[0].size() != 0 || q[1].size() != 0) idle(1);
    chk("drain_left", 32'(q[0].size() + q[1].size()), 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++)
      cycle(1, $urandom, 2'($urandom), 1'($urandom),
            5'($urandom), 0, 0, 0, 0, -1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    LoadValid = 0; Stall = 0; Flush = 0;
    #1 chk_zero_outs("midreset");
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'h2, 2'd0, 0, 5'd21, 0, 0, 1, 32'h00008000, 0);
    idle(1);
    for (int i = 0; i < 20; i++)
      if (q[0].size() != 0 || q[1].size() != 0) idle(1);
    chk("final_left", 32'(q[0].size() + q[1].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
